// File: rtl/sipo_frame_controller_pkg.sv
// sipo_pkg: shared state encoding and default frame width for the SIPO frame receiver.
package sipo_pkg;
    localparam int DEF_WIDTH = 4;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/sipo_frame_controller_if.sv
// sipo_frame_controller_if: parallel word valid/ready handshake between receiver and consumer.
interface sipo_frame_controller_if import sipo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] Pout_data;
    logic             Pout_valid;
    logic             Pout_ready;
    modport master (output Pout_data, output Pout_valid, input Pout_ready);
    modport slave  (input Pout_data, input Pout_valid, output Pout_ready);
endinterface

// File: rtl/sipo_shift_datapath.sv
// sipo_shift_datapath: WIDTH-bit left shift register, first bit ends up in the MSB.
module sipo_shift_datapath import sipo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             shift_en,
    input  logic             sync_clr,
    input  logic             Sin,
    output logic [WIDTH-1:0] sr
);
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) sr <= '0;
        else if (sync_clr) sr <= '0;
        else if (shift_en) sr <= {sr[WIDTH-2:0], Sin};
    end
endmodule

// File: rtl/sipo_frame_controller.sv
// sipo_frame_controller: framed serial receiver; counts strobed bits, hands completed words
// downstream over valid/ready and flags words dropped while the holding register is full.
module sipo_frame_controller import sipo_pkg::*; #(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                     Clock,
    input  logic                     Clear,
    input  logic                     Start,
    input  logic                     Sin,
    input  logic                     Sin_valid,
    input  logic                     Clear_overrun,
    sipo_frame_controller_if.master  pout,
    output logic                     Busy,
    output logic [CNT_W-1:0]         Bit_count,
    output logic                     Overrun
);
    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             shifting, done, xfer;
    assign shifting = (state == ST_SHIFT) && !Start && Sin_valid;
    assign done     = shifting && (Bit_count == CNT_W'(WIDTH - 1));
    assign xfer     = pout.Pout_valid && pout.Pout_ready;
    sipo_shift_datapath #(.WIDTH(WIDTH)) u_dp (
        .Clock    (Clock),
        .Clear    (Clear),
        .shift_en (shifting),
        .sync_clr (Start),
        .Sin      (Sin),
        .sr       (sr)
    );
    // The completing bit is folded in directly so the word lands in the holding register on the same edge.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state           <= ST_IDLE;
            Busy            <= 1'b0;
            Bit_count       <= '0;
            Overrun         <= 1'b0;
            pout.Pout_data  <= '0;
            pout.Pout_valid <= 1'b0;
        end else begin
            state     <= Start ? ST_SHIFT : done ? ST_IDLE : state;
            Busy      <= Start || ((state == ST_SHIFT) && !done);
            Bit_count <= (Start || done) ? '0 : shifting ? Bit_count + 1'b1 : Bit_count;
            Overrun   <= (done && pout.Pout_valid && !xfer) ? 1'b1 : Clear_overrun ? 1'b0 : Overrun;
            if (done && (!pout.Pout_valid || xfer)) begin
                pout.Pout_data  <= {sr[WIDTH-2:0], Sin};
                pout.Pout_valid <= 1'b1;
            end else if (xfer) begin
                pout.Pout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sipo_frame_controller.sv
// tb_sipo_frame_controller: vector table, directed corner sequences and random traffic
// checked against a queue-based frame model.
module tb_sipo_frame_controller;
    localparam int W = 4;
    localparam int CW = $clog2(W + 1);
    logic Clock = 0, Clear = 0, Start = 0, Sin = 0, Sin_valid = 0, Clear_overrun = 0;
    logic Busy, Overrun;
    logic [CW-1:0] Bit_count;
    int n_chk = 0, n_fail = 0;
    sipo_frame_controller_if #(.WIDTH(W)) pif ();
    sipo_frame_controller #(.WIDTH(W)) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Sin(Sin), .Sin_valid(Sin_valid),
        .Clear_overrun(Clear_overrun), .pout(pif), .Busy(Busy), .Bit_count(Bit_count), .Overrun(Overrun)
    );
    always #5 Clock = ~Clock;
    bit m_bits[$];
    bit m_in_frame = 0, m_valid = 0, m_ovr = 0;
    logic [W-1:0] m_data = '0;
    typedef struct {
        bit st, s, v, co, rdy;
        logic [W-1:0] e_data;
        bit e_valid, e_busy;
        int e_cnt;
        bit e_ovr;
    } vec_t;
    vec_t vt[7];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_bits.delete();
        m_in_frame = 0; m_valid = 0; m_ovr = 0; m_data = '0;
    endtask
    task automatic model_step(input bit st, s, v, co, rdy);
        bit comp = 0, xf;
        logic [W-1:0] w = '0;
        xf = m_valid && rdy;
        if (st) begin
            m_in_frame = 1;
            m_bits.delete();
        end else if (m_in_frame && v) begin
            m_bits.push_back(s);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
                comp = 1;
                m_in_frame = 0;
                m_bits.delete();
            end
        end
        if (co) m_ovr = 0;
        if (comp && m_valid && !xf) m_ovr = 1;
        if (comp && (!m_valid || xf)) begin
            m_data = w;
            m_valid = 1;
        end else if (xf) m_valid = 0;
    endtask
    task automatic check_model();
        chk("data", 32'(pif.Pout_data), 32'(m_data));
        chk("valid", 32'(pif.Pout_valid), 32'(m_valid));
        chk("busy", 32'(Busy), 32'(m_in_frame));
        chk("count", 32'(Bit_count), 32'(m_bits.size()));
        chk("overrun", 32'(Overrun), 32'(m_ovr));
    endtask
    task automatic step(input bit st, s, v, co, rdy);
        Start = st; Sin = s; Sin_valid = v; Clear_overrun = co; pif.Pout_ready = rdy;
        @(posedge Clock);
        #1;
        model_step(st, s, v, co, rdy);
        check_model();
        Start = 0; Sin_valid = 0; Clear_overrun = 0; pif.Pout_ready = 0;
    endtask
    task automatic frame(input logic [W-1:0] w, input bit rdy_last);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) step(0, w[W-1-i], 1, 0, (i == W - 1) ? rdy_last : 1'b0);
    endtask
    initial begin
        pif.Pout_ready = 0;
        vt[0] = '{1, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0};
        vt[1] = '{0, 1, 1, 0, 0, 4'b0000, 0, 1, 1, 0};
        vt[2] = '{0, 0, 1, 0, 0, 4'b0000, 0, 1, 2, 0};
        vt[3] = '{0, 1, 1, 0, 0, 4'b0000, 0, 1, 3, 0};
        vt[4] = '{0, 1, 1, 0, 0, 4'b1011, 1, 0, 0, 0};
        vt[5] = '{0, 0, 1, 0, 0, 4'b1011, 1, 0, 0, 0};
        vt[6] = '{0, 0, 0, 0, 1, 4'b1011, 0, 0, 0, 0};
        #12;
        chk("rst_data", 32'(pif.Pout_data), 0);
        chk("rst_valid", 32'(pif.Pout_valid), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_count", 32'(Bit_count), 0);
        chk("rst_overrun", 32'(Overrun), 0);
        @(negedge Clock) Clear = 1;
        // basic frame from the table
        foreach (vt[i]) begin
            step(vt[i].st, vt[i].s, vt[i].v, vt[i].co, vt[i].rdy);
            chk("tbl_data", 32'(pif.Pout_data), 32'(vt[i].e_data));
            chk("tbl_valid", 32'(pif.Pout_valid), 32'(vt[i].e_valid));
            chk("tbl_busy", 32'(Busy), 32'(vt[i].e_busy));
            chk("tbl_count", 32'(Bit_count), 32'(vt[i].e_cnt));
            chk("tbl_overrun", 32'(Overrun), 32'(vt[i].e_ovr));
        end
        // async clear mid-frame
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        Clear = 0;
        #1;
        model_reset();
        chk("async_busy", 32'(Busy), 0);
        chk("async_count", 32'(Bit_count), 0);
        chk("async_valid", 32'(pif.Pout_valid), 0);
        chk("async_data", 32'(pif.Pout_data), 0);
        #2 Clear = 1;
        frame(4'b1101, 0);
        chk("post_rst_word", 32'(pif.Pout_data), 32'h0000000d);
        step(0, 0, 0, 0, 1);
        // gapped strobes
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            automatic logic [W-1:0] gw = 4'b0110;
            for (int g = 0, n = $urandom_range(1, 3); g < n; g++) step(0, 1, 0, 0, 0);
            step(0, gw[W-1-i], 1, 0, 0);
        end
        chk("gapped_word", 32'(pif.Pout_data), 32'h00000006);
        step(0, 0, 0, 0, 1);
        // restart drops partial frame
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("restart_count", 32'(Bit_count), 0);
        for (int i = 0; i < W; i++) begin
            step(0, i == W - 1, 1, 0, 0);
            if (i < W - 1) chk("restart_no_valid", 32'(pif.Pout_valid), 0);
        end
        chk("restart_word", 32'(pif.Pout_data), 32'h00000001);
        step(0, 0, 0, 0, 1);
        // overrun
        frame(4'b1010, 0);
        step(0, 0, 0, 0, 0);
        frame(4'b0101, 0);
        chk("ovr_word_kept", 32'(pif.Pout_data), 32'h0000000a);
        chk("ovr_set", 32'(Overrun), 1);
        step(0, 0, 0, 0, 1);
        chk("ovr_drained", 32'(pif.Pout_valid), 0);
        chk("ovr_sticky", 32'(Overrun), 1);
        step(0, 0, 0, 1, 0);
        chk("ovr_cleared", 32'(Overrun), 0);
        // transfer and completion on the same edge
        frame(4'b1111, 0);
        frame(4'b1001, 1);
        chk("simul_word", 32'(pif.Pout_data), 32'h00000009);
        chk("simul_valid", 32'(pif.Pout_valid), 1);
        chk("simul_no_ovr", 32'(Overrun), 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_frame_controller.md
Name: sipo_frame_controller

Overview:
Sequences a WIDTH-bit serial-in/parallel-out shift datapath as a framed receiver. Gates shift enables from a bit strobe, counts bits per frame, and transfers the completed word into an output holding register. Presents the word downstream through a valid/ready handshake and flags overruns. Sits between a serial bit source and any parallel consumer in the design.

Parameters:
WIDTH, 4, bits per frame and parallel output width (min 2)
CNT_W, $clog2(WIDTH+1), bit counter width (derived, not overridden)

Ports:
Clock  input  1  system clock, rising edge
Clear  input  1  asynchronous active-low reset
Start  input  1  frame start pulse; begins or restarts a frame
Sin  input  1  serial data bit
Sin_valid  input  1  Sin is sampled this cycle (shift strobe)
Clear_overrun  input  1  synchronous clear of sticky Overrun
Pout_ready  input  1  downstream accepts Pout_data this cycle
Pout_data  output  WIDTH  completed parallel word (holding register)
Pout_valid  output  1  Pout_data holds an unconsumed word
Busy  output  1  frame in progress (state SHIFT)
Bit_count  output  CNT_W  bits captured in current frame
Overrun  output  1  sticky: a completed frame was dropped

Behaviour:
- One clock, Clock. Reset is Clear, asynchronous and active-low. While Clear=0: state=IDLE, shift register=0, Pout_data=0, Pout_valid=0, Busy=0, Bit_count=0, Overrun=0. Clear asserted mid-frame aborts the frame and discards partial data.
- States: IDLE, SHIFT.
- IDLE: Sin_valid is ignored. Start=1 -> SHIFT, with Bit_count=0 and shift register=0 on the next edge.
- SHIFT: Busy=1. Each edge with Sin_valid=1 shifts left: sr <= {sr[WIDTH-2:0], Sin}, and Bit_count increments. The first bit lands in the MSB.
- Start=1 in SHIFT: restart. Bit_count=0, sr=0, state stays SHIFT. Restart wins over a same-cycle Sin_valid, and that bit is dropped.
- Completion: an edge where Sin_valid=1 and Bit_count==WIDTH-1 captures the last bit. The next state is IDLE, and the full word goes to the holding register on that same edge, so Pout_valid rises exactly 1 cycle after the last strobe is sampled. Bit_count returns to 0.
- A Start coinciding with the completing strobe is treated as restart; the frame is not completed.
- Handshake: a word transfers on an edge with Pout_valid=1 and Pout_ready=1. Pout_valid and Pout_data stay stable until transfer. Pout_ready while Pout_valid=0 has no effect.
- Transfer and completion on the same edge: the new word is loaded, Pout_valid stays 1, and there is no overrun.
- Completion while Pout_valid=1 and no transfer that edge: the new word is dropped, the held word is kept, and Overrun is set to 1 on that edge.
- Overrun is sticky until Clear_overrun=1, which clears it on the next edge. If a set and a clear hit the same edge, set wins.
- Sin_valid exactly at the completing edge counts; Sin_valid after completion, in IDLE, is ignored.

Decomposition:
- Shared package sipo_pkg holds the state encoding constants (ST_IDLE=1'b0, ST_SHIFT=1'b1) and the default WIDTH.
- Sub-module sipo_shift_datapath holds the WIDTH-bit register. Inputs: Clock, Clear, shift_en, sync_clr, Sin. Output: sr.
- The controller owns the FSM, bit counter, holding register and flags.

Test Plan:
- Reset: Clear=0 mid-frame after 2 bits -> all outputs 0 immediately (async). After release, frame Start plus bits 1,1,0,1 -> Pout_data=4'b1101.
- Basic frame: Start, then Sin_valid on 4 consecutive edges with Sin=1,0,1,1 -> Busy=1 for 4 cycles, Pout_valid=1 one cycle after the 4th strobe, Pout_data=4'b1011, Bit_count back to 0.
- Gapped strobes: bits 0,1,1,0 with 1-3 idle cycles between strobes -> Pout_data=4'b0110. Bit_count holds between strobes.
- Restart: Start, bits 1,1, Start again, bits 0,0,0,1 -> Pout_data=4'b0001. Only one Pout_valid pulse.
- Overrun: complete 4'b1010 with Pout_ready=0, then complete 4'b0101 -> Pout_data stays 4'b1010 and Overrun=1. Pout_ready=1 drains it. Clear_overrun=1 -> Overrun=0 next edge.
- Simultaneous: hold word 4'b1111 valid, and make the next frame complete on the same edge Pout_ready=1 -> Pout_data=new word, Pout_valid stays 1, Overrun stays 0.
